// File: rtl/bd_ser_pkg.sv
// Shared definitions for the BD word serializer: leaf codes, per-leaf BD
// data widths and the default per-leaf part-count table derived from them.
package bd_ser_pkg;

   localparam int unsigned NCODE      = 8;
   localparam int unsigned NLEAF      = 14;
   localparam int unsigned NIN        = 38;
   localparam int unsigned NDATA_OUT  = 24;
   localparam int unsigned NMAX_PARTS = 2;
   localparam int unsigned NIDX       = 1;
   localparam int unsigned NPART_W    = 4;

   typedef enum logic [NCODE-1:0] {
      LEAF_DUMP_AM    = 8'd0,
      LEAF_WR_REG     = 8'd1,
      LEAF_WR_MEM     = 8'd2,
      LEAF_ACK        = 8'd3,
      LEAF_FIFO_OVF   = 8'd4,
      LEAF_HB         = 8'd5,
      LEAF_DUMP_TAT0  = 8'd6,
      LEAF_DUMP_TAT1  = 8'd7,
      LEAF_DUMP_PAT   = 8'd8,
      LEAF_DUMP_MM    = 8'd9,
      LEAF_DUMP_REG   = 8'd10,
      LEAF_RO_ACC     = 8'd11,
      LEAF_RO_TAT     = 8'd12,
      LEAF_RO_TAT_AUX = 8'd13
   } leaf_code_e;

   // BD data width carried by each leaf; leaves not listed fit in one part
   function automatic int unsigned leaf_width(input logic [NCODE-1:0] code);
      case (code)
         LEAF_DUMP_AM:                   return 38;
         LEAF_DUMP_TAT0, LEAF_DUMP_TAT1: return 29;
         LEAF_RO_ACC:                    return 28;
         LEAF_RO_TAT, LEAF_RO_TAT_AUX:   return 32;
         default:                        return NDATA_OUT;
      endcase
   endfunction

   function automatic int unsigned parts_for_width(input int unsigned w);
      return (w + NDATA_OUT - 1) / NDATA_OUT;
   endfunction

   function automatic logic [NLEAF*NPART_W-1:0] build_parts();
      logic [NLEAF*NPART_W-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < NLEAF; i++) begin
         p[i*NPART_W +: NPART_W] = NPART_W'(parts_for_width(leaf_width(NCODE'(i))));
      end
      return p;
   endfunction

   localparam logic [NLEAF*NPART_W-1:0] DEFAULT_PARTS = build_parts();

endpackage

// File: rtl/bd_part_select.sv
// Combinational part mux: returns the Ndata_out-wide slice of the held word
// selected by idx_i; out-of-range indices yield zero.
//   payload_i : held word, Nmax_parts*Ndata_out bits, zero-extended
//   idx_i     : part index, 0 = least-significant part
//   part_o    : selected part
module bd_part_select
   import bd_ser_pkg::*;
#(
   parameter int unsigned Nidx       = NIDX,
   parameter int unsigned Ndata_out  = NDATA_OUT,
   parameter int unsigned Nmax_parts = NMAX_PARTS
) (
   input  logic [Nmax_parts*Ndata_out-1:0] payload_i,
   input  logic [Nidx-1:0]                 idx_i,
   output logic [Ndata_out-1:0]            part_o
);

   always_comb begin
      part_o = '0;
      for (int unsigned i = 0; i < Nmax_parts; i++) begin
         if (idx_i == Nidx'(i)) part_o = payload_i[i*Ndata_out +: Ndata_out];
      end
   end

endmodule

// File: rtl/bd_multipart_serializer.sv
// Splits a decoded BD word into 1..Nmax_parts output parts with index/last
// tagging and valid/accept handshakes on both sides.
//   clk, reset          : clock, synchronous active-low reset
//   in_v/in_a           : input handshake; in_a depends only on state and out_a
//   in_code/in_payload  : leaf code and decoded payload
//   out_v/out_a         : output handshake
//   out_code            : leaf code of the held word
//   out_payload         : current part
//   out_idx/out_last    : part number and final-part flag
module bd_multipart_serializer
   import bd_ser_pkg::*;
#(
   parameter int unsigned Ncode      = NCODE,
   parameter int unsigned Nleaf      = NLEAF,
   parameter int unsigned Nin        = NIN,
   parameter int unsigned Ndata_out  = NDATA_OUT,
   parameter int unsigned Nmax_parts = NMAX_PARTS,
   parameter int unsigned Nidx       = NIDX,
   parameter logic [Nleaf*NPART_W-1:0] PARTS = DEFAULT_PARTS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_v,
   output logic                 in_a,
   input  logic [Ncode-1:0]     in_code,
   input  logic [Nin-1:0]       in_payload,
   output logic                 out_v,
   input  logic                 out_a,
   output logic [Ncode-1:0]     out_code,
   output logic [Ndata_out-1:0] out_payload,
   output logic [Nidx-1:0]      out_idx,
   output logic                 out_last
);

   localparam int unsigned NHOLD = Nmax_parts * Ndata_out;

   typedef enum logic {S_IDLE, S_BUSY} state_e;

   state_e             state_q, state_d;
   logic [Ncode-1:0]   hold_code_q, hold_code_d;
   logic [NHOLD-1:0]   hold_payload_q, hold_payload_d;
   logic [Nidx-1:0]    hold_last_q, hold_last_d;
   logic [Nidx-1:0]    cnt_q, cnt_d;

   logic               busy;
   logic               in_fire;
   logic               out_fire;
   logic [NPART_W-1:0] n_parts;

   assign busy     = (state_q == S_BUSY);
   assign out_v    = busy;
   assign out_code = hold_code_q;
   assign out_idx  = cnt_q;
   assign out_last = busy & (cnt_q == hold_last_q);
   assign in_a     = ~busy | (out_a & out_last);
   assign in_fire  = in_v & in_a;
   assign out_fire = busy & out_a;

   // Part count for the incoming code, clamped to 1..Nmax_parts
   always_comb begin
      n_parts = NPART_W'(1);
      for (int unsigned i = 0; i < Nleaf; i++) begin
         if (in_code == Ncode'(i)) n_parts = PARTS[i*NPART_W +: NPART_W];
      end
      if (n_parts == '0) n_parts = NPART_W'(1);
      else if (n_parts > NPART_W'(Nmax_parts)) n_parts = NPART_W'(Nmax_parts);
   end

   // Next state: a new word loads on the same edge the last part leaves
   always_comb begin
      state_d        = state_q;
      hold_code_d    = hold_code_q;
      hold_payload_d = hold_payload_q;
      hold_last_d    = hold_last_q;
      cnt_d          = cnt_q;
      if (in_fire) begin
         state_d        = S_BUSY;
         hold_code_d    = in_code;
         hold_payload_d = NHOLD'(in_payload);
         hold_last_d    = Nidx'(n_parts - NPART_W'(1));
         cnt_d          = '0;
      end else if (out_fire) begin
         if (out_last) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + Nidx'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         hold_code_q    <= '0;
         hold_payload_q <= '0;
         hold_last_q    <= '0;
         cnt_q          <= '0;
      end else begin
         state_q        <= state_d;
         hold_code_q    <= hold_code_d;
         hold_payload_q <= hold_payload_d;
         hold_last_q    <= hold_last_d;
         cnt_q          <= cnt_d;
      end
   end

   bd_part_select #(
      .Nidx       (Nidx),
      .Ndata_out  (Ndata_out),
      .Nmax_parts (Nmax_parts)
   ) u_part_select (
      .payload_i (hold_payload_q),
      .idx_i     (cnt_q),
      .part_o    (out_payload)
   );

endmodule

// File: tb/tb_bd_multipart_serializer.sv
// Directed bench for bd_multipart_serializer with hand-computed expectations.
module tb_bd_multipart_serializer;

   logic        clk;
   logic        reset;
   logic        in_v;
   logic        in_a;
   logic [7:0]  in_code;
   logic [37:0] in_payload;
   logic        out_v;
   logic        out_a;
   logic [7:0]  out_code;
   logic [23:0] out_payload;
   logic [0:0]  out_idx;
   logic        out_last;

   int total = 0;
   int bad   = 0;

   bd_multipart_serializer dut (
      .clk         (clk),
      .reset       (reset),
      .in_v        (in_v),
      .in_a        (in_a),
      .in_code     (in_code),
      .in_payload  (in_payload),
      .out_v       (out_v),
      .out_a       (out_a),
      .out_code    (out_code),
      .out_payload (out_payload),
      .out_idx     (out_idx),
      .out_last    (out_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic [7:0] code, input logic [23:0] pay,
                       input logic idx, input logic last, input logic ina);
      #1;
      chk({tag, "_v"},    64'(out_v), 64'(1'b1));
      chk({tag, "_code"}, 64'(out_code), 64'(code));
      chk({tag, "_pay"},  64'(out_payload), 64'(pay));
      chk({tag, "_idx"},  64'(out_idx), 64'(idx));
      chk({tag, "_last"}, 64'(out_last), 64'(last));
      chk({tag, "_ina"},  64'(in_a), 64'(ina));
   endtask

   task automatic idle_chk(input string tag);
      #1;
      chk({tag, "_v"},   64'(out_v), 64'(1'b0));
      chk({tag, "_ina"}, 64'(in_a), 64'(1'b1));
   endtask

   initial begin
      reset = 1'b0; in_v = 1'b0; out_a = 1'b0; in_code = '0; in_payload = '0;
      tick(); tick();
      #1;
      chk("rst_v",    64'(out_v), 64'(1'b0));
      chk("rst_ina",  64'(in_a), 64'(1'b1));
      chk("rst_last", 64'(out_last), 64'(1'b0));
      chk("rst_idx",  64'(out_idx), 64'(1'b0));
      chk("rst_pay",  64'(out_payload), 64'(24'h0));
      chk("rst_code", 64'(out_code), 64'(8'h0));
      reset = 1'b1;
      tick();
      idle_chk("post_rst");

      // out_a while idle must not disturb anything
      out_a = 1'b1;
      tick(); tick();
      idle_chk("idle_oa");

      // Single-part word
      in_v = 1'b1; in_code = 8'd3; in_payload = 38'h00_00AB_CDEF;
      tick();
      in_v = 1'b0;
      beat("sp", 8'd3, 24'hABCDEF, 1'b0, 1'b1, 1'b1);
      tick();
      idle_chk("sp_end");

      // Two-part word
      in_v = 1'b1; in_code = 8'd0; in_payload = 38'h2A_1234_5678;
      tick();
      in_v = 1'b0;
      beat("tp0", 8'd0, 24'h345678, 1'b0, 1'b0, 1'b0);
      tick();
      beat("tp1", 8'd0, 24'h002A12, 1'b1, 1'b1, 1'b1);
      tick();
      idle_chk("tp_end");

      // Backpressure on beat1 of a code-12 word with a queued word
      in_v = 1'b1; in_code = 8'd12; in_payload = 38'h3F_FFAA_BBCC;
      tick();
      in_v = 1'b0;
      beat("bp0", 8'd12, 24'hAABBCC, 1'b0, 1'b0, 1'b0);
      tick();
      out_a = 1'b0;
      in_v = 1'b1; in_code = 8'd3; in_payload = 38'h00_0012_3456;
      for (int i = 0; i < 5; i++) begin
         beat("bp_hold", 8'd12, 24'h003FFF, 1'b1, 1'b1, 1'b0);
         tick();
      end
      out_a = 1'b1;
      beat("bp_rel", 8'd12, 24'h003FFF, 1'b1, 1'b1, 1'b1);
      tick();
      in_v = 1'b0;
      beat("bp_next", 8'd3, 24'h123456, 1'b0, 1'b1, 1'b1);
      tick();
      idle_chk("bp_end");

      // Streaming eight single-part words
      in_v = 1'b1; in_code = 8'd3; in_payload = 38'(24'hC0FFE0);
      tick();
      for (int i = 1; i <= 8; i++) begin
         logic [23:0] exp_pay;
         exp_pay = 24'hC0FFE0 + 24'(i - 1);
         if (i < 8) in_payload = 38'(24'hC0FFE0 + 24'(i));
         else       in_v = 1'b0;
         beat("st", 8'd3, exp_pay, 1'b0, 1'b1, 1'b1);
         tick();
      end
      idle_chk("st_end");

      // Invalid code: single part, upper bits dropped
      in_v = 1'b1; in_code = 8'd20; in_payload = 38'h3F_8765_4321;
      tick();
      in_v = 1'b0;
      beat("inv", 8'd20, 24'h654321, 1'b0, 1'b1, 1'b1);
      tick();
      idle_chk("inv_end");

      // Reset mid-word discards the remaining part
      in_v = 1'b1; in_code = 8'd6; in_payload = 38'h15_0000_0001;
      tick();
      in_v = 1'b0;
      beat("rm0", 8'd6, 24'h000001, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      #1;
      chk("rm_v",   64'(out_v), 64'(1'b0));
      chk("rm_ina", 64'(in_a), 64'(1'b1));
      reset = 1'b1;
      in_v = 1'b1; in_code = 8'd3; in_payload = 38'h00_0077_7777;
      tick();
      in_v = 1'b0;
      beat("rm_new", 8'd3, 24'h777777, 1'b0, 1'b1, 1'b1);
      tick();
      idle_chk("rm_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bd_multipart_serializer.md
Name: bd_multipart_serializer

Overview:
Parametrised successor to the fixed two-state BD-word serializer. It splits a decoded BD word of up to Nin bits into 1..Nmax_parts output payloads of Ndata_out bits each. The number of parts per leaf code comes from a parameter table. It sits between the BD horn decoder and the PC-bound word channel. It adds three things the previous block lacked: a registered holding stage, part index/last tagging, and handshakes qualified by valid.

Parameters:
Ncode, 8, width of leaf code field
Nleaf, 14, number of valid leaf codes (codes >= Nleaf are invalid)
Nin, 38, input payload width (longest BD data width)
Ndata_out, 24, output payload width
Nmax_parts, 2, ceil(Nin/Ndata_out); max parts per word
Nidx, 1, clog2(Nmax_parts), min 1; width of part index
PARTS, packed Nleaf x 4 bits, per-leaf part count; default 2 for codes 0,6,7,11,12,13 and 1 elsewhere

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
in_v  in  1  input word valid
in_a  out  1  input accept (transfer when in_v & in_a)
in_code  in  Ncode  leaf code
in_payload  in  Nin  decoded BD payload
out_v  out  1  output part valid
out_a  in  1  output accept (transfer when out_v & out_a)
out_code  out  Ncode  leaf code of held word
out_payload  out  Ndata_out  current part
out_idx  out  Nidx  part number, 0 = least-significant part
out_last  out  1  current part is final part of word

Behaviour:
- One clock; reset is synchronous and active-low. While reset==0 at a clk edge: busy=0, part counter=0, holding regs=0. All outputs are 0 except in_a=1.
- State: busy flag, hold_code, hold_payload (Nin, zero-extended to Nmax_parts*Ndata_out), hold_nparts, cnt (Nidx).
- Part count lookup at input transfer: n = PARTS[in_code]. If in_code >= Nleaf, n=1. If n==0, n=1. If n>Nmax_parts, n=Nmax_parts.
- out_v = busy. out_code = hold_code. out_idx = cnt. out_payload = hold_payload[cnt*Ndata_out +: Ndata_out]; bits above Nin are 0. out_last = (cnt == hold_nparts-1).
- in_a = ~busy | (out_a & out_last). Combinational on out_a only, never on in_v.
- Output transfer, not last: cnt <= cnt+1.
- Output transfer, last, with no input transfer: busy<=0, cnt<=0.
- Input transfer (same cycle as a last-part output transfer, or while idle): load hold regs, busy<=1, cnt<=0.
- Latency: a word accepted at edge k presents part 0 at cycle k+1. Throughput is one part per cycle, and back-to-back single-part words issue with no bubble.
- out_a while out_v==0 has no effect; the counter never advances without a transfer.
- Output is stable: while out_v & ~out_a, all out_* hold their values.
- Reset mid-word discards the remaining parts. out_v is 0 in the cycle after reset is released.

Decomposition:
- Shared package (bd_ser_pkg): leaf code enumerations, the BD data widths per leaf (DUMP_AM 38, DUMP_TAT0/1 29, RO_ACC 28, RO_TAT 32), a default PARTS table, and a function computing ceil(width/Ndata_out) to build PARTS.
- One sub-module, bd_part_select: a combinational mux taking (hold_payload, cnt) and producing the zero-filled Ndata_out slice. It is reusable by the deserializer verification model.

Test Plan:
- Single-part word: code 3, payload 38'h00_00AB_CDEF, out_a=1 -> one beat out_payload 24'hABCDEF, out_idx 0, out_last 1, out_code 3.
- Two-part word: code 0, payload 38'h2A_1234_5678 -> beat0 payload 24'h345678 idx0 last0, then beat1 payload 24'h002A12 idx1 last1; in_a low during beat0.
- Backpressure: code 12, out_a held 0 for 5 cycles during beat1 -> all outputs are constant and in_a=0. On release, one transfer occurs, then the next queued word loads in the same cycle.
- Streaming: 8 consecutive code-3 words with out_a=1 -> 8 beats on 8 consecutive cycles, in_a constantly 1.
- Invalid code 20 with a 38-bit payload -> a single beat with the low 24 bits and out_last=1; the upper bits are dropped.
- Reset (reset=0) asserted after beat0 of a code-6 word -> out_v=0 and in_a=1 the next cycle. A new code-3 word then emits correctly with out_idx 0.
